// File: rtl/btc_job_dispatcher.sv
// Launches a bank of miner cores on equal nonce slices and
// drains their found nonces to the host one at a time.
module btc_job_dispatcher #(
    parameter int NUM_CORES   = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [31:0]             job_offset,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES*32-1:0] core_nonce_in,
    output logic                    core_use_nonce_in,
    output logic                    core_oneshot,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [NUM_CORES*32-1:0] core_nonce_out,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [31:0]             result_nonce,
    output logic [3:0]              result_core,
    output logic                    job_done,
    output logic                    job_error,
    output logic [4:0]              job_found_count
);

    localparam int SHIFT = 32 - $clog2(NUM_CORES);
    localparam int AW    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_RUN,
        S_END
    } state_t;

    state_t                    state;
    logic [NUM_CORES-1:0]      pending;
    logic [NUM_CORES-1:0]      done_q;
    logic [4:0]                fcnt;
    logic [AW-1:0]             ack_cnt;

    logic [NUM_CORES*32-1:0]   slice_start;
    logic [NUM_CORES-1:0]      first;
    logic [NUM_CORES-1:0]      set_mask;
    logic [NUM_CORES-1:0]      pop_mask;
    logic [NUM_CORES-1:0]      pending_nxt;
    logic [31:0]               nonce_sel;
    logic [3:0]                sel;
    logic                      hit;

    function automatic logic [4:0] popcnt(input logic [NUM_CORES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_CORES; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    always_comb begin
        slice_start = '0;
        first       = '0;
        nonce_sel   = '0;
        sel         = '0;
        hit         = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slice_start[32*i +: 32] = (32'(i) << SHIFT) + job_offset;
            // Lowest pending index wins; its nonce is held by the idle core.
            if (pending[i] && !hit) begin
                hit       = 1'b1;
                sel       = 4'(i);
                first[i]  = 1'b1;
                nonce_sel = core_nonce_out[32*i +: 32];
            end
        end
        set_mask    = (state == S_RUN) ? (core_done & ~done_q & core_found) : '0;
        pop_mask    = (result_valid && result_ready) ? first : '0;
        pending_nxt = (pending & ~pop_mask) | set_mask;
    end

    assign job_ready         = (state == S_IDLE);
    assign core_use_nonce_in = 1'b1;
    assign core_oneshot      = 1'b0;
    assign result_valid      = |pending;
    assign result_core       = sel;
    assign result_nonce      = result_valid ? nonce_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            core_start      <= '0;
            core_nonce_in   <= '0;
            pending         <= '0;
            done_q          <= '0;
            fcnt            <= '0;
            ack_cnt         <= '0;
            job_done        <= 1'b0;
            job_error       <= 1'b0;
            job_found_count <= '0;
        end else begin
            done_q          <= core_done;
            pending         <= pending_nxt;
            job_done        <= 1'b0;
            job_error       <= 1'b0;
            job_found_count <= '0;
            unique case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        core_nonce_in <= slice_start;
                        core_start    <= ~core_start;
                        pending       <= '0;
                        fcnt          <= '0;
                        ack_cnt       <= '0;
                        state         <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_cnt <= ack_cnt + 1'b1;
                    if (core_done == '0) begin
                        state <= S_RUN;
                    end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        state     <= S_END;
                        job_done  <= 1'b1;
                        job_error <= 1'b1;
                    end
                end
                S_RUN: begin
                    fcnt <= fcnt + popcnt(set_mask);
                    // pending_nxt==0 implies no new find this cycle
                    if (&core_done && pending_nxt == '0) begin
                        state           <= S_END;
                        job_done        <= 1'b1;
                        job_found_count <= fcnt;
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btc_job_dispatcher.sv
// Directed and randomized checks of btc_job_dispatcher against
// a slice/result-set reference model.
module tb_btc_job_dispatcher;

    localparam int N = 4;

    typedef int          fin_t[N];
    typedef logic [31:0] nz_t[N];

    logic            clk = 1'b0;
    logic            rst;
    logic            job_valid;
    logic            job_ready;
    logic [31:0]     job_offset;
    logic [N-1:0]    core_start;
    logic [N*32-1:0] core_nonce_in;
    logic            core_use_nonce_in;
    logic            core_oneshot;
    logic [N-1:0]    core_done;
    logic [N-1:0]    core_found;
    logic [N*32-1:0] core_nonce_out;
    logic            result_valid;
    logic            result_ready;
    logic [31:0]     result_nonce;
    logic [3:0]      result_core;
    logic            job_done;
    logic            job_error;
    logic [4:0]      job_found_count;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_sb = '0;
    logic [31:0]  exp_nonce[N];
    int           pop_log[$];

    btc_job_dispatcher #(.NUM_CORES(N), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_offset(job_offset),
        .core_start(core_start), .core_nonce_in(core_nonce_in),
        .core_use_nonce_in(core_use_nonce_in),
        .core_oneshot(core_oneshot),
        .core_done(core_done), .core_found(core_found),
        .core_nonce_out(core_nonce_out),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_nonce(result_nonce), .result_core(result_core),
        .job_done(job_done), .job_error(job_error),
        .job_found_count(job_found_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice_model(input int i, input logic [31:0] off);
        logic [63:0] s;
        s = 64'(i) * (64'h1_0000_0000 / 64'(N)) + 64'(off);
        return s[31:0];
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk_reset();
        chk("rst_job_ready", 64'(job_ready), 1);
        chk("rst_use_nonce", 64'(core_use_nonce_in), 1);
        chk("rst_oneshot", 64'(core_oneshot), 0);
        chk("rst_core_start", 64'(core_start), 0);
        chk("rst_nonce_lo", core_nonce_in[63:0], 0);
        chk("rst_nonce_hi", core_nonce_in[127:64], 0);
        chk("rst_res_valid", 64'(result_valid), 0);
        chk("rst_res_nonce", 64'(result_nonce), 0);
        chk("rst_res_core", 64'(result_core), 0);
        chk("rst_job_done", 64'(job_done), 0);
        chk("rst_job_error", 64'(job_error), 0);
        chk("rst_found_cnt", 64'(job_found_count), 0);
    endtask

    task automatic launch(input logic [31:0] off);
        job_offset = off;
        job_valid  = 1'b1;
        step();
        job_valid = 1'b0;
        exp_sb    = ~exp_sb;
        for (int i = 0; i < N; i++) begin
            exp_nonce[i] = slice_model(i, off);
            chk($sformatf("launch_nonce%0d", i),
                64'(core_nonce_in[32*i +: 32]), 64'(exp_nonce[i]));
        end
        chk("launch_start", 64'(core_start), 64'(exp_sb));
        chk("launch_ready", 64'(job_ready), 0);
    endtask

    task automatic ack();
        step();
        step();
        step();
        core_done  = '0;
        core_found = '0;
        step();
        step();
        chk("ack_no_done", 64'(job_done), 0);
    endtask

    task automatic run_job(input fin_t fin, input logic [N-1:0] fmask,
                           input nz_t nz, input int rmode);
        logic [N-1:0] unrep;
        logic [N-1:0] nxt;
        logic         r;
        logic         ended;
        logic         got;
        logic         expd;
        int           lo;
        unrep = '0;
        ended = 1'b0;
        got   = 1'b0;
        pop_log.delete();
        for (int t = 0; t < 80 && !got; t++) begin
            job_valid  = (t < 3);
            job_offset = $urandom;
            for (int i = 0; i < N; i++) begin
                if (fin[i] == t) begin
                    core_done[i]  = 1'b1;
                    core_found[i] = fmask[i];
                    core_nonce_out[32*i +: 32] = nz[i];
                end
            end
            case (rmode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: r = (t >= 25);
            endcase
            result_ready = r;
            nxt = unrep;
            if (unrep != '0 && r) begin
                lo = lowest(unrep);
                nxt[lo] = 1'b0;
                pop_log.push_back(lo);
            end
            for (int i = 0; i < N; i++)
                if (fin[i] == t && fmask[i]) nxt[i] = 1'b1;
            step();
            unrep = nxt;
            expd  = (&core_done) && (unrep == '0) && !ended;
            chk("res_valid", 64'(result_valid), 64'(unrep != '0));
            chk("res_core", 64'(result_core), 64'(unrep != '0 ? lowest(unrep) : 0));
            chk("res_nonce", 64'(result_nonce), 64'(unrep != '0 ? nz[lowest(unrep)] : 32'h0));
            chk("job_done", 64'(job_done), 64'(expd));
            if (expd) begin
                ended = 1'b1;
                chk("found_count", 64'(job_found_count), 64'($countones(fmask)));
                chk("job_error", 64'(job_error), 0);
            end
            if (job_done) got = 1'b1;
        end
        job_valid    = 1'b0;
        result_ready = 1'b0;
        chk("job_done_seen", 64'(got), 1);
        chk("ignored_start", 64'(core_start), 64'(exp_sb));
        for (int i = 0; i < N; i++)
            chk("ignored_nonce", 64'(core_nonce_in[32*i +: 32]), 64'(exp_nonce[i]));
        step();
        chk("ready_after", 64'(job_ready), 1);
    endtask

    initial begin
        fin_t fin;
        nz_t  nz;
        rst            = 1'b1;
        job_valid      = 1'b0;
        job_offset     = '0;
        result_ready   = 1'b0;
        core_done      = '1;
        core_found     = '0;
        core_nonce_out = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        chk_reset();
        rst = 1'b0;
        step();

        launch(32'h10);
        chk("launch_c0", 64'(core_nonce_in[31:0]), 64'h10);
        chk("launch_c1", 64'(core_nonce_in[63:32]), 64'h4000_0010);
        chk("launch_c2", 64'(core_nonce_in[95:64]), 64'h8000_0010);
        chk("launch_c3", 64'(core_nonce_in[127:96]), 64'hC000_0010);
        ack();
        fin = '{3, 1, 3, 1};
        nz  = '{32'h0000_00AB, 32'h0, 32'h8000_1234, 32'h0};
        run_job(fin, 4'b0101, nz, 0);
        chk("simul_pops", 64'(pop_log.size()), 2);
        if (pop_log.size() == 2) begin
            chk("simul_first", 64'(pop_log[0]), 0);
            chk("simul_second", 64'(pop_log[1]), 2);
        end

        launch(32'hFFFF_FFF0);
        chk("wrap_c1", 64'(core_nonce_in[63:32]), 64'h3FFF_FFF0);
        chk("wrap_c3", 64'(core_nonce_in[127:96]), 64'hBFFF_FFF0);
        ack();
        fin = '{2, 2, 5, 2};
        nz  = '{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
        run_job(fin, 4'b0100, nz, 2);
        chk("bp_pops", 64'(pop_log.size()), 1);

        for (int j = 0; j < 6; j++) begin
            launch($urandom);
            ack();
            for (int i = 0; i < N; i++) begin
                fin[i] = $urandom_range(0, 8);
                nz[i]  = $urandom;
            end
            run_job(fin, 4'($urandom), nz, 1);
        end

        launch(32'h1234_5678);
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) core_done = 4'b1000;
            step();
            chk($sformatf("to_done_k%0d", k), 64'(job_done), 64'(k == 8));
            if (k == 8) begin
                chk("to_error", 64'(job_error), 1);
                chk("to_count", 64'(job_found_count), 0);
            end
            if (k == 9) chk("to_idle", 64'(job_ready), 1);
        end
        core_done = '1;
        step();

        launch(32'h0);
        ack();
        core_done[1]  = 1'b1;
        core_found[1] = 1'b1;
        core_nonce_out[63:32] = 32'h5555_AAAA;
        step();
        chk("rr_pending", 64'(result_valid), 1);
        rst = 1'b1;
        step();
        chk_reset();
        exp_sb    = '0;
        rst       = 1'b0;
        core_done = '1;
        step();
        chk("rr_ready", 64'(job_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btc_job_dispatcher.md
# btc_job_dispatcher

Sequences a bank of `NUM_CORES` BtcMinerCore instances for one mining job. It splits the 32-bit nonce space into equal slices and launches every core with its slice start. It then waits for all cores to finish and reports each found nonce to the host through a valid/ready result port. It sits between the host register interface and the core bank, on the core clock.

## Interface

Parameters:
- `NUM_CORES`, default 4: number of cores; power of two, 1..16.
- `ACK_TIMEOUT`, default 8: maximum cycles from launch for every core's `done` to fall.

Ports, given as name, direction, width, meaning:
- `clk` in 1: the single clock for the block and the cores.
- `rst` in 1: synchronous, active-high reset.
- `job_valid` in 1: the host offers a job.
- `job_ready` out 1: the block can accept a job; high only in IDLE.
- `job_offset` in 32: nonce offset added to every slice start.
- `core_start` out NUM_CORES: per-core start toggle, wired to `start_a`.
- `core_nonce_in` out NUM_CORES*32: per-core start nonce, wired to `nonce_in_a`; core i uses bits [32i+31:32i].
- `core_use_nonce_in` out 1: constant 1.
- `core_oneshot` out 1: constant 0.
- `core_done` in NUM_CORES: per-core `done`.
- `core_found` in NUM_CORES: per-core `nonce_found_flag`.
- `core_nonce_out` in NUM_CORES*32: per-core `nonce_out`.
- `result_valid` out 1: a found nonce is pending.
- `result_ready` in 1: the host accepts the pending result.
- `result_nonce` out 32: the reported nonce.
- `result_core` out 4: index of the core that found the reported nonce.
- `job_done` out 1: one-cycle pulse when a job ends.
- `job_error` out 1: qualifies `job_done`; set when a core failed to acknowledge launch.
- `job_found_count` out 5: number of found nonces in the job; valid with `job_done`.

## Operation

- **Slices.** `SLICE = 2^32 / NUM_CORES`. The start nonce for core i is `core_nonce_in[i] = i*SLICE + job_offset`, computed mod 2^32 with no saturation.
- **Core end nonces.** Top level instantiates each core with `NONCE_MAX` equal to the end of its slice. The dispatcher has no means to stop a running core.
- **IDLE.** `job_ready = 1`. On `job_valid & job_ready`:
  - register all `core_nonce_in` values;
  - invert every bit of `core_start`;
  - clear `pending`, the found counter and the ACK counter;
  - go to ACK.
- **ACK.** The counter increments each cycle.
  - When all `core_done` bits are low, go to RUN.
  - If the counter reaches `ACK_TIMEOUT` with any `done` still high, go to END with the error flag set.
- **RUN.** `done_q` registers `core_done` every cycle in every state.
  - A rising edge on core i (`core_done[i] & ~done_q[i]`) with `core_found[i]=1` sets `pending[i]` and increments the found counter.
  - When all `core_done` bits are high and `pending == 0`, go to END.
- **END.** Lasts one cycle.
  - `job_done = 1`.
  - `job_error` = the error flag.
  - `job_found_count` = the counter value; 0 on error.
  - Then go to IDLE.
- **Result port.**
  - `result_valid = |pending`.
  - `result_core` = the lowest set index in `pending`.
  - `result_nonce = core_nonce_out[result_core]`, which is stable because the finished core holds `nonce_out` in its IDLE state.
  - `result_valid & result_ready` clears that one `pending` bit.
- **Outputs are not hashed.** The dispatcher does not re-hash results; verification of a found nonce is host software's job.
- **Boundary conditions.**
  - Several cores rising in the same cycle: all set `pending` and the counter adds the popcount. They are reported in ascending index order, one per accepted handshake.
  - Pop of bit j and set of bit k in the same cycle: both take effect.
  - `job_valid` outside IDLE is ignored and no state changes.
  - A core that finishes without finding a nonce sets no `pending` bit.
  - `result_ready` held low stalls END indefinitely; cores stay idle.
- **Reset** clears `state` to IDLE, and clears `core_start`, `core_nonce_in`, `pending`, the counters, `done_q`, the error flag, `job_done` and `job_error`. Reset mid-job abandons the job.
  - `rst` must be asserted together with the core reset. A lone dispatcher reset with `core_start=1` is a start toggle on the core side.

## Timing

- Job accept at edge 0: `core_start` and `core_nonce_in` change at edge 0.
- Cores drop `done` at edge 4. The dispatcher is in RUN from edge 5, and `ACK_TIMEOUT = 8` leaves margin.
- Earliest core finish is 132+ cycles after launch.
- `result_valid` rises 1 cycle after the core's `done` rises.
- `job_done` rises 1 cycle after the last `done`/`pending` condition is met. `job_ready` returns 1 the cycle after `job_done`.
- Accept-to-next-accept is at least 3 cycles plus core runtime.
- Reset values of outputs:
  - `job_ready = 1`;
  - `core_use_nonce_in = 1`;
  - all other outputs are 0.

## Test plan

- **Launch.** `NUM_CORES=4`, `job_offset=0x10` → `core_nonce_in` = 0x10, 0x4000_0010, 0x8000_0010, 0xC000_0010; all 4 `core_start` bits toggle at edge 0; `job_ready=0` from edge 1.
- **Wrap.** `job_offset=0xFFFF_FFF0` → core 1 gets 0x3FFF_FFF0, core 3 gets 0xBFFF_FFF0.
- **Simultaneous finds.** Core models for cores 2 and 0 raise `done` with found in the same cycle, nonces 0x8000_1234 and 0x0000_00AB; `result_ready` held at 1 → results in the order core 0/0xAB then core 2/0x8000_1234; `job_done=1`, `job_found_count=2`, `job_error=0`.
- **Backpressure.** One find with `result_ready=0` for 20 cycles → `result_valid` held with a stable nonce, no `job_done` until the pop; `job_done` pulses 1 cycle after the pop.
- **ACK timeout.** Core 3 keeps `done=1` → `job_done=1` and `job_error=1` at ACK cycle 8, `job_found_count=0`, then IDLE.
- **Reset in RUN.** Assert `rst` during RUN → next cycle all outputs are at reset values and `job_ready=1`.
